// File: rtl/fp_dot_mac_pkg.sv
// Shared types, default widths and exponent helpers for the small-float dot-product MAC.
package fp_dot_mac_pkg;

  localparam int DEF_EXP_W  = 3;
  localparam int DEF_FRAC_W = 4;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Exponent bias for a field of the given width.
  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Largest finite biased exponent (all-ones field).
  function automatic int fp_emax(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

endpackage

// File: rtl/fp_small_mul.sv
// Combinational small-float multiply: hidden-one product, one-step normalise,
// truncation toward zero, then saturate/flush range handling.
import fp_dot_mac_pkg::*;

module fp_small_mul #(
  parameter int EXP_W  = DEF_EXP_W,
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic [EXP_W+FRAC_W:0] a,
  input  logic [EXP_W+FRAC_W:0] b,
  output logic [EXP_W+FRAC_W:0] prod,
  output logic                  ovf,
  output logic                  uvf
);

  localparam int W  = 1 + EXP_W + FRAC_W;
  localparam int MW = FRAC_W + 1;
  localparam int PW = 2 * MW;
  localparam int EW = EXP_W + 3;
  localparam logic signed [EW-1:0] BIAS = EW'(fp_bias(EXP_W));
  localparam logic signed [EW-1:0] EMAX = EW'(fp_emax(EXP_W));
  localparam logic signed [EW-1:0] EMIN = EW'(1);

  logic [EXP_W-1:0]     ea_s;
  logic [EXP_W-1:0]     eb_s;
  logic [PW-1:0]        mp_s;
  logic signed [EW-1:0] e_s;
  logic [FRAC_W-1:0]    f_s;
  logic                 sign_s;
  logic                 unused_lsb_s;

  // Truncated product bits below the kept fraction never reach the result.
  assign unused_lsb_s = ^mp_s[FRAC_W-1:0];

  // Multiply mantissas, renormalise once on carry, then range-check the exponent.
  always_comb begin
    ea_s   = a[FRAC_W +: EXP_W];
    eb_s   = b[FRAC_W +: EXP_W];
    sign_s = a[W-1] ^ b[W-1];
    mp_s   = PW'({1'b1, a[FRAC_W-1:0]}) * PW'({1'b1, b[FRAC_W-1:0]});
    e_s    = EW'(ea_s) + EW'(eb_s) - BIAS;
    if (mp_s[PW-1]) begin
      e_s = e_s + EW'(1);
      f_s = mp_s[PW-2 -: FRAC_W];
    end else begin
      f_s = mp_s[PW-3 -: FRAC_W];
    end
    prod = '0;
    ovf  = 1'b0;
    uvf  = 1'b0;
    if (ea_s == '0 || eb_s == '0) begin
      prod = '0;
    end else if (e_s > EMAX) begin
      prod = {sign_s, {(W-1){1'b1}}};
      ovf  = 1'b1;
    end else if (e_s < EMIN) begin
      prod = '0;
      uvf  = 1'b1;
    end else begin
      prod = {sign_s, e_s[EXP_W-1:0], f_s};
    end
  end

endmodule

// File: rtl/fp_dot_mac.sv
// Length-programmed small-float dot product: stage 1 registers the product,
// stage 2 aligns and adds it into the accumulator; sticky range flags per run.
import fp_dot_mac_pkg::*;

module fp_dot_mac #(
  parameter int EXP_W  = DEF_EXP_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNT_W-1:0]      len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXP_W+FRAC_W:0] a,
  input  logic [EXP_W+FRAC_W:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_W+FRAC_W:0] result,
  output logic                  ovf,
  output logic                  uvf,
  output logic                  busy
);

  localparam int W   = 1 + EXP_W + FRAC_W;
  localparam int MW  = FRAC_W + 1;
  localparam int LZW = $clog2(MW + 1);
  localparam int EW  = EXP_W + LZW + 2;
  localparam logic signed [EW-1:0] EMAX = EW'(fp_emax(EXP_W));
  localparam logic signed [EW-1:0] EMIN = EW'(1);

  state_t           state_r;
  logic [CNT_W-1:0] count_r;
  logic             s1_valid_r;
  logic [W-1:0]     s1_prod_r;
  logic             s1_ovf_r;
  logic             s1_uvf_r;
  logic [W-1:0]     acc_r;
  logic [W-1:0]     result_r;
  logic             ovf_r;
  logic             uvf_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;

  logic             beat_s;
  logic [W-1:0]     mul_prod_s;
  logic             mul_ovf_s;
  logic             mul_uvf_s;

  logic             x_zero_s;
  logic             y_zero_s;
  logic             x_big_s;
  logic [W-1:0]     big_s;
  logic [W-1:0]     small_s;
  logic [EXP_W-1:0] eb_s;
  logic [EXP_W-1:0] es_s;
  logic [MW-1:0]    mb_s;
  logic [MW-1:0]    ms_s;
  logic [MW:0]      sum_s;
  logic [MW-1:0]    diff_s;
  logic [LZW-1:0]   lz_s;
  logic             found_s;
  logic [FRAC_W-1:0] sub_frac_s;
  logic signed [EW-1:0] ae_s;
  logic [W-1:0]     add_res_s;
  logic             add_ovf_s;
  logic             add_uvf_s;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign ovf       = ovf_r;
  assign uvf       = uvf_r;
  assign busy      = busy_r;
  assign beat_s    = in_valid & in_ready_r;

  fp_small_mul #(
    .EXP_W  (EXP_W),
    .FRAC_W (FRAC_W)
  ) u_mul (
    .a    (a),
    .b    (b),
    .prod (mul_prod_s),
    .ovf  (mul_ovf_s),
    .uvf  (mul_uvf_s)
  );

  // Align the smaller magnitude to the larger, add or subtract, renormalise, range-check.
  always_comb begin
    x_zero_s = (acc_r[FRAC_W +: EXP_W] == '0);
    y_zero_s = (s1_prod_r[FRAC_W +: EXP_W] == '0);
    x_big_s  = (acc_r[W-2:0] >= s1_prod_r[W-2:0]);
    big_s    = x_big_s ? acc_r : s1_prod_r;
    small_s  = x_big_s ? s1_prod_r : acc_r;
    eb_s     = big_s[FRAC_W +: EXP_W];
    es_s     = small_s[FRAC_W +: EXP_W];
    mb_s     = {1'b1, big_s[FRAC_W-1:0]};
    ms_s     = {1'b1, small_s[FRAC_W-1:0]} >> (eb_s - es_s);
    sum_s    = {1'b0, mb_s} + {1'b0, ms_s};
    diff_s   = mb_s - ms_s;
    lz_s     = '0;
    found_s  = 1'b0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (!found_s) begin
        if (diff_s[i]) begin
          found_s = 1'b1;
        end else begin
          lz_s = lz_s + LZW'(1);
        end
      end else begin
        found_s = 1'b1;
      end
    end
    sub_frac_s = FRAC_W'(diff_s << lz_s);
    ae_s      = '0;
    add_res_s = '0;
    add_ovf_s = 1'b0;
    add_uvf_s = 1'b0;
    if (x_zero_s) begin
      add_res_s = s1_prod_r;
    end else if (y_zero_s) begin
      add_res_s = acc_r;
    end else if (big_s[W-1] == small_s[W-1]) begin
      ae_s = EW'(eb_s);
      if (sum_s[MW]) begin
        ae_s      = ae_s + EW'(1);
        add_res_s = {big_s[W-1], ae_s[EXP_W-1:0], sum_s[MW-1 -: FRAC_W]};
      end else begin
        add_res_s = {big_s[W-1], ae_s[EXP_W-1:0], sum_s[FRAC_W-1:0]};
      end
      if (ae_s > EMAX) begin
        add_res_s = {big_s[W-1], {(W-1){1'b1}}};
        add_ovf_s = 1'b1;
      end else begin
        add_ovf_s = 1'b0;
      end
    end else if (diff_s == '0) begin
      add_res_s = '0;
    end else begin
      ae_s = EW'(eb_s) - EW'(lz_s);
      if (ae_s < EMIN) begin
        add_res_s = '0;
        add_uvf_s = 1'b1;
      end else begin
        add_res_s = {big_s[W-1], ae_s[EXP_W-1:0], sub_frac_s};
      end
    end
  end

  // Control FSM, product/accumulator pipeline and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      count_r     <= '0;
      s1_valid_r  <= 1'b0;
      s1_prod_r   <= '0;
      s1_ovf_r    <= 1'b0;
      s1_uvf_r    <= 1'b0;
      acc_r       <= '0;
      result_r    <= '0;
      ovf_r       <= 1'b0;
      uvf_r       <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      s1_valid_r <= beat_s;
      if (beat_s) begin
        s1_prod_r <= mul_prod_s;
        s1_ovf_r  <= mul_ovf_s;
        s1_uvf_r  <= mul_uvf_s;
      end
      if (s1_valid_r) begin
        acc_r <= add_res_s;
        ovf_r <= ovf_r | s1_ovf_r | add_ovf_s;
        uvf_r <= uvf_r | s1_uvf_r | add_uvf_s;
      end
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            acc_r   <= '0;
            ovf_r   <= 1'b0;
            uvf_r   <= 1'b0;
            count_r <= len;
            busy_r  <= 1'b1;
            if (len != '0) begin
              state_r    <= ST_ACCUM;
              in_ready_r <= 1'b1;
            end else begin
              state_r     <= ST_DONE;
              out_valid_r <= 1'b1;
              result_r    <= '0;
            end
          end
        end
        ST_ACCUM: begin
          if (beat_s) begin
            count_r <= count_r - CNT_W'(1);
            if (count_r == CNT_W'(1)) begin
              state_r    <= ST_FLUSH;
              in_ready_r <= 1'b0;
            end
          end
        end
        ST_FLUSH: begin
          state_r     <= ST_DONE;
          out_valid_r <= 1'b1;
          result_r    <= add_res_s;
        end
        ST_DONE: begin
          if (out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_dot_mac.sv
// Randomised and directed bench for fp_dot_mac against a value-level dot-product model.
module tb_fp_dot_mac;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] len;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       ovf;
  logic       uvf;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] pa [16];
  logic [7:0] pb [16];
  int         gap[16];

  always #5 clk = ~clk;

  fp_dot_mac dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovf       (ovf),
    .uvf       (uvf),
    .busy      (busy)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pack sign, normalised mantissa (16..31) and unbiased-in-field exponent with range rules.
  function automatic logic [9:0] ref_pack(input int s, input int m, input int e);
    logic [7:0] v;
    if (e > 7) begin
      v = {s[0], 7'h7F};
      return {2'b10, v};
    end
    if (e < 1) return 10'h100;
    v = {s[0], e[2:0], m[3:0]};
    return {2'b00, v};
  endfunction

  function automatic logic [9:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
    int ex = int'(x[6:4]);
    int ey = int'(y[6:4]);
    int m;
    int e;
    int s;
    if (ex == 0 || ey == 0) return 10'h000;
    s = int'(x[7] ^ y[7]);
    m = (16 + int'(x[3:0])) * (16 + int'(y[3:0]));
    e = ex + ey - 3;
    while (m >= 512) begin
      m = m / 2;
      e++;
    end
    return ref_pack(s, m / 16, e);
  endfunction

  function automatic logic [9:0] ref_add(input logic [7:0] x, input logic [7:0] y);
    longint vx;
    longint vy;
    logic [7:0] bg;
    logic [7:0] sm;
    int mb, eb, ms, es, al, t, s, mag, e;
    if (x[6:4] == 3'd0) return {2'b00, y};
    if (y[6:4] == 3'd0) return {2'b00, x};
    vx = longint'(16 + int'(x[3:0])) << int'(x[6:4]);
    vy = longint'(16 + int'(y[3:0])) << int'(y[6:4]);
    if (vx >= vy) begin bg = x; sm = y; end
    else begin bg = y; sm = x; end
    mb = 16 + int'(bg[3:0]);
    eb = int'(bg[6:4]);
    ms = 16 + int'(sm[3:0]);
    es = int'(sm[6:4]);
    al = ms >> (eb - es);
    t  = (bg[7] ? -mb : mb) + (sm[7] ? -al : al);
    if (t == 0) return 10'h000;
    s   = (t < 0) ? 1 : 0;
    mag = (t < 0) ? -t : t;
    e   = eb;
    while (mag >= 32) begin mag = mag / 2; e++; end
    while (mag < 16) begin mag = mag * 2; e--; end
    return ref_pack(s, mag, e);
  endfunction

  function automatic logic [9:0] ref_dot(input int n);
    logic [7:0] acc = 8'h00;
    logic o = 1'b0;
    logic u = 1'b0;
    logic [9:0] p;
    logic [9:0] r;
    for (int i = 0; i < n; i++) begin
      p = ref_mul(pa[i], pb[i]);
      r = ref_add(acc, p[7:0]);
      o = o | p[9] | r[9];
      u = u | p[8] | r[8];
      acc = r[7:0];
    end
    return {o, u, acc};
  endfunction

  task automatic run_dot(input string name, input int n, input int hold, input int want);
    logic [9:0] expv;
    int cnt;
    expv = ref_dot(n);
    @(negedge clk);
    start = 1'b1;
    len   = n[7:0];
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap[i]; g++) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      a = pa[i];
      b = pb[i];
      cnt = 0;
      while (!in_ready && cnt < 20) begin
        @(negedge clk);
        cnt++;
      end
      if (cnt >= 20) check_val({name, "_ready_timeout"}, in_ready, 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (n > 0) begin
      check_val({name, "_lat_early"}, out_valid, 0);
      @(negedge clk);
    end
    check_val({name, "_lat"}, out_valid, 1);
    cnt = 0;
    while (!out_valid && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    for (int h = 0; h < hold; h++) begin
      check_val({name, "_hold_res"}, result, expv[7:0]);
      check_val({name, "_hold_rdy"}, {in_ready, out_valid}, 1);
      @(negedge clk);
    end
    check_val({name, "_res"}, result, expv[7:0]);
    check_val({name, "_ovf"}, ovf, expv[9]);
    check_val({name, "_uvf"}, uvf, expv[8]);
    if (want >= 0) check_val({name, "_abs"}, result, want[7:0]);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_val({name, "_drain"}, {out_valid, busy}, 0);
  endtask

  task automatic set_pair(input int i, input logic [7:0] x, input logic [7:0] y, input int g);
    pa[i] = x;
    pb[i] = y;
    gap[i] = g;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    len = 8'h00;
    in_valid = 1'b0;
    a = 8'h00;
    b = 8'h00;
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) gap[i] = 0;
    #1;
    check_val("rst_outputs", {out_valid, in_ready, busy, ovf, uvf}, 0);
    check_val("rst_result", result, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    set_pair(0, 8'h40, 8'h38, 0);
    run_dot("one_beat", 1, 0, 8'h48);

    set_pair(0, 8'h30, 8'h30, 0);
    set_pair(1, 8'h30, 8'h30, 1);
    set_pair(2, 8'h40, 8'h30, 1);
    run_dot("gaps", 3, 0, 8'h50);

    set_pair(0, 8'h30, 8'h40, 0);
    set_pair(1, 8'hB0, 8'h40, 0);
    run_dot("cancel", 2, 0, 8'h00);

    set_pair(0, 8'h70, 8'h70, 0);
    run_dot("ovf", 1, 0, 8'h7F);
    set_pair(0, 8'h10, 8'h10, 0);
    run_dot("uvf", 1, 0, 8'h00);

    // len=0: immediate DONE, held while the consumer stalls, start ignored.
    @(negedge clk);
    start = 1'b1;
    len = 8'h00;
    @(negedge clk);
    start = 1'b0;
    check_val("len0_valid", out_valid, 1);
    for (int h = 0; h < 5; h++) begin
      check_val("len0_hold", {out_valid, in_ready, result}, 32'h200);
      start = (h == 2) ? 1'b1 : 1'b0;
      len = 8'h03;
      @(negedge clk);
    end
    start = 1'b0;
    check_val("len0_start_ignored", {out_valid, busy, in_ready}, 32'h6);
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b0;
    check_val("len0_drain", {out_valid, busy}, 0);
    @(negedge clk);
    check_val("len0_stay_idle", {busy, in_ready}, 0);

    // Asynchronous reset mid-accumulation after two of four beats.
    start = 1'b1;
    len = 8'h04;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    a = 8'h30;
    b = 8'h30;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check_val("pre_rst_busy", {busy, in_ready}, 3);
    #2;
    reset = 1'b0;
    #1;
    check_val("async_rst", {out_valid, busy, in_ready}, 0);
    check_val("async_rst_res", result, 0);
    @(negedge clk);
    reset = 1'b1;
    set_pair(0, 8'h30, 8'h30, 0);
    run_dot("after_rst", 1, 0, 8'h30);

    // Randomised dot products.
    for (int r = 0; r < 40; r++) begin
      int n;
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) begin
        logic [7:0] x;
        logic [7:0] y;
        if ($urandom_range(0, 1) == 0) begin
          x = 8'($urandom);
          y = 8'($urandom);
        end else begin
          x = {1'($urandom), 3'($urandom_range(2, 4)), 4'($urandom)};
          y = {1'($urandom), 3'($urandom_range(2, 4)), 4'($urandom)};
        end
        if ($urandom_range(0, 9) == 0) x[6:4] = 3'd0;
        set_pair(i, x, y, $urandom_range(0, 2));
      end
      run_dot($sformatf("rnd%0d", r), n, $urandom_range(0, 2), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_dot_mac.md
Name: fp_dot_mac

Overview:
Parametrised successor to the 8-bit FP multiply-accumulate block. It computes a length-programmed dot product of small-float operand pairs through a 2-stage pipeline (multiply, then align/add into the accumulator). Operands arrive over a valid/ready stream and the result leaves over a valid/ready output. Sticky overflow and underflow flags are reported with each result.

Parameters:
EXP_W, 3, exponent field width; bias = 2^(EXP_W-1)-1
FRAC_W, 4, stored fraction width (hidden leading 1 implied)
CNT_W, 8, width of the beat counter and of len

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse that begins a dot product; honoured only in IDLE
len  in  CNT_W  number of operand pairs; sampled with start
in_valid  in  1  operand pair valid
in_ready  out  1  block accepts a pair this cycle
a  in  W  operand A; W = 1+EXP_W+FRAC_W; layout {sign, exp, frac}
b  in  W  operand B
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
result  out  W  accumulated sum
ovf  out  1  sticky overflow flag for the current dot product
uvf  out  1  sticky underflow flag for the current dot product
busy  out  1  state != IDLE

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, accumulator=0, beat count=0, stage-1 valid=0, ovf=uvf=0, out_valid=0, in_ready=0, result=0. Asserting reset mid-operation discards all work; no partial result is emitted.
- Encoding: exp field 0 means zero, whatever the fraction. There are no denormals, no inf and no NaN. Max finite = exp all-ones, frac all-ones.
- FSM states: IDLE, ACCUM, FLUSH, DONE.
- IDLE: in_ready=0.
  - start with len!=0 -> ACCUM; clears accumulator, ovf and uvf; count<=len.
  - start with len==0 -> DONE with result 0; out_valid is high on the next cycle.
- ACCUM: in_ready=1. Each beat (in_valid & in_ready) decrements count, and the product is registered in stage 1 at that edge. Gaps in in_valid are allowed. When the final beat is accepted at edge k -> FLUSH; stage-1 adds into the accumulator at edge k+1.
- FLUSH: in_ready=0. At edge k+1 the last add commits and the FSM goes to DONE, so out_valid=1 from edge k+1. Fixed latency: 2 edges from product acceptance to accumulator update.
- DONE: out_valid=1; result, ovf and uvf are held stable until out_valid & out_ready, then -> IDLE. start is ignored in ACCUM, FLUSH and DONE, including when it coincides with the out handshake; it must be reissued in IDLE.
- Multiply:
  - Sign = xor of operand signs; exponent = ea+eb-bias.
  - Mantissa product (1.fa)*(1.fb) is 2*(FRAC_W+1) bits. Shift right 1 and increment the exponent if the MSB is set. Truncate to FRAC_W bits (round toward zero).
  - A zero operand gives an exact +0 product, but the beat still counts.
- Add:
  - Align the smaller-exponent operand right by the exponent difference; shifted-out bits are dropped.
  - Equal signs add, with renormalise on carry. Unequal signs subtract the smaller magnitude from the larger, with a leading-zero renormalise. Exact cancellation gives +0.
- Range (both stages): exponent > 2^EXP_W-1 saturates to ±max finite and sets ovf. Exponent < 1 flushes to +0 and sets uvf. Flags are sticky until the next accepted start.

Decomposition:
- fp_dot_mac_pkg: FSM state enum; field-width localparams derived from EXP_W/FRAC_W; bias constant; max-finite and zero encoding constants.
- One combinational sub-module, fp_small_mul: parametrised multiply with range handling, returning {product, ovf, uvf}.
- Alignment/add stays inline in fp_dot_mac.

Test Plan:
- Defaults (bias 3): start len=1; beat a=0x40 (2.0), b=0x38 (1.5) -> out_valid 2 edges after acceptance, result=0x48 (3.0), ovf=uvf=0.
- len=3; pairs (0x30,0x30), (0x30,0x30), (0x40,0x30) with one idle cycle between beats -> result=0x50 (4.0).
- len=2; pairs (0x30,0x40), (0xB0,0x40) -> exact cancellation, result=0x00, no flags.
- len=1; a=0x70, b=0x70 (16*16) -> result=0x7F, ovf=1. Then len=1; a=0x10, b=0x10 (0.25*0.25) -> result=0x00, uvf=1, ovf cleared by the new start.
- len=0 -> out_valid next cycle, result=0x00. Hold out_ready=0 for 5 cycles -> result stable, in_ready=0; a start pulse during DONE is ignored.
- Assert reset during ACCUM after 2 of 4 beats -> out_valid=0, result=0, state IDLE immediately (asynchronous). A fresh start with len=1, (0x30,0x30) -> result=0x30.
